ddr_lane_delay_sequencer: RTL and testbench
===========================================

Name: ddr_lane_delay_sequencer

Overview:
- Fabric-side master for the DDR PHY lane controller's delay-line and clock-pause control inputs.
- Accepts tap-adjust requests (LOAD / INC / DEC for the RX or TX DQS delay line) from training logic over a valid/ready handshake.
- Generates correctly timed SEL/DIRECTION/LOAD/MOVE strobes and wraps LOAD in an HS_IO_CLK_PAUSE window.
- Tracks current tap counts and returns a per-request status.

Parameters:
- TAP_W, 8, width of tap counters.
- MAX_TAP, 255, highest legal tap; must fit in TAP_W.
- LOAD_TAP, 1, tap value after reset or a LOAD operation; matches the lane's programmed delay value.
- SETUP_CYCLES, 2, cycles SEL/DIRECTION are stable before the strobe; must be at least 1.
- HOLD_CYCLES, 2, cycles after the strobe before OUT_OF_RANGE is sampled; must be at least 1.
- PAUSE_CYCLES, 4, cycles HS_IO_CLK_PAUSE is held before and after a LOAD strobe; must be at least 1.

Ports:
- FAB_CLK  in  1  fabric clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  request accepted when REQ_VALID and REQ_READY are both high.
- REQ_OP  in  2  00 LOAD, 01 INC, 10 DEC, 11 reserved.
- REQ_LANE  in  1  0 selects the RX delay line, 1 selects the TX delay line.
- RSP_VALID  out  1  one-cycle completion pulse.
- RSP_ERR  out  1  status, valid with RSP_VALID.
- RX_TAP  out  TAP_W  current RX tap.
- TX_TAP  out  TAP_W  current TX tap.
- DELAY_LINE_SEL  out  1  to lane controller; 0 RX, 1 TX.
- DELAY_LINE_LOAD  out  1  load strobe.
- DELAY_LINE_DIRECTION  out  1  1 increment, 0 decrement.
- DELAY_LINE_MOVE  out  1  move strobe.
- HS_IO_CLK_PAUSE  out  1  clock-pause request to the lane pause synchroniser.
- RX_DELAY_LINE_OUT_OF_RANGE  in  1  from lane controller.
- TX_DELAY_LINE_OUT_OF_RANGE  in  1  from lane controller.

Behaviour:
- Clock and reset: one clock (FAB_CLK); RESET is synchronous and active-high.
- Registered outputs: all outputs are registered.
- Reset values: REQ_READY=0, RSP_VALID=0, RSP_ERR=0, RX_TAP=TX_TAP=LOAD_TAP, every DELAY_LINE_* output=0, HS_IO_CLK_PAUSE=0, state=IDLE.
- REQ_READY: rises the first cycle after RESET deasserts. High only in IDLE; drops the cycle after a request is accepted. REQ_OP and REQ_LANE are captured at acceptance.
- FSM states: IDLE, PAUSE_ON, SETUP, STROBE, HOLD, PAUSE_OFF, RESP.
- IDLE transitions on accept:
  - LOAD goes to PAUSE_ON.
  - INC or DEC goes to SETUP.
  - Reserved op, INC at MAX_TAP, or DEC at 0 goes straight to RESP with an error; no strobe is issued.
- PAUSE_ON: HS_IO_CLK_PAUSE=1 for PAUSE_CYCLES cycles, then SETUP. Pause stays 1 continuously through SETUP, STROBE, HOLD and PAUSE_OFF for a LOAD.
- SETUP: DELAY_LINE_SEL=lane and DIRECTION=(op==INC) held for SETUP_CYCLES cycles. SEL and DIRECTION stay stable through STROBE and HOLD.
- STROBE: exactly one cycle with MOVE=1 (INC/DEC) or LOAD=1 (LOAD). MOVE and LOAD are never high together.
- HOLD: lasts HOLD_CYCLES cycles. The selected lane's OUT_OF_RANGE is sampled on the last HOLD cycle.
  - Sampled high: RSP_ERR=1 and the tap is left unchanged.
  - Sampled low: tap is set to LOAD_TAP, +1 or −1 for LOAD, INC or DEC respectively; the update is visible in RESP.
- After HOLD: LOAD goes to PAUSE_OFF (pause held PAUSE_CYCLES more cycles, then drops on RESP entry); otherwise RESP.
- RESP: RSP_VALID=1 for one cycle, SEL/DIRECTION return to 0, then IDLE (REQ_READY=1 the next cycle).
- Latency, with acceptance at cycle 0 and default parameters:
  - INC/DEC: MOVE high at cycle 3; RSP_VALID at cycle 6.
  - LOAD: pause high cycles 1–13; LOAD strobe at cycle 7; RSP_VALID at cycle 14.
  - Error-bypass: RSP_VALID at cycle 1.
- Back-to-back requests: the minimum spacing is RSP cycle + 1. REQ_VALID held high across RESP is accepted in the following IDLE cycle.
- OUT_OF_RANGE outside HOLD: ignored.
- RESET mid-operation: all outputs return to reset values on that edge, including an immediate drop of HS_IO_CLK_PAUSE and MOVE/LOAD. Taps go to LOAD_TAP and no RSP is produced for the aborted request.
- Arithmetic: tap arithmetic never wraps; the saturation checks are performed at acceptance against the current tap.

Test Plan:
- Reset, then INC on TX (REQ_OP=01, REQ_LANE=1) -> SEL=1 and DIRECTION=1 from cycle 1; MOVE single pulse at cycle 3; RSP_VALID at 6 with RSP_ERR=0; TX_TAP 1->2; RX_TAP stays 1.
- LOAD on RX after three RX INCs (tap 4) -> pause high cycles 1–13; LOAD pulse at cycle 7 with SEL=0; RSP at 14; RX_TAP=1.
- DEC on RX at tap 0 (one DEC from reset) -> no MOVE; RSP_VALID at cycle 1 with RSP_ERR=1; tap stays 0. Reserved op 11 -> same error response.
- INC on TX with TX_DELAY_LINE_OUT_OF_RANGE=1 during the last HOLD cycle -> RSP_ERR=1 and TX_TAP unchanged. The same pulse applied during SETUP instead -> RSP_ERR=0.
- RESET asserted at cycle 8 of a LOAD -> HS_IO_CLK_PAUSE=0 and REQ_READY=0 on the next edge; no RSP_VALID; taps=1; a new INC after release completes normally.
- REQ_VALID held high with 4 queued INCs -> acceptances exactly 7 cycles apart; 4 RSP_VALID pulses; tap=5.

Source files
------------

// File: rtl/ddr_lane_delay_sequencer_if.sv
// Request/response handshake between the DDR training logic and the lane delay sequencer.
// The training logic is the master and the sequencer is the slave.
interface ddr_lane_delay_sequencer_if;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [1:0] REQ_OP;
    logic       REQ_LANE;
    logic       RSP_VALID;
    logic       RSP_ERR;

    modport master (
        output REQ_VALID, REQ_OP, REQ_LANE,
        input  REQ_READY, RSP_VALID, RSP_ERR
    );

    modport slave (
        input  REQ_VALID, REQ_OP, REQ_LANE,
        output REQ_READY, RSP_VALID, RSP_ERR
    );
endinterface

// File: rtl/ddr_lane_delay_sequencer.sv
// Sequences DQS delay-line LOAD/INC/DEC strobes into the DDR lane controller and
// wraps LOAD in an HS_IO_CLK_PAUSE window. It also tracks the RX/TX tap counts.
module ddr_lane_delay_sequencer #(
    parameter int TAP_W        = 8,
    parameter int MAX_TAP      = 255,
    parameter int LOAD_TAP     = 1,
    parameter int SETUP_CYCLES = 2,
    parameter int HOLD_CYCLES  = 2,
    parameter int PAUSE_CYCLES = 4
) (
    input  logic                 FAB_CLK,
    input  logic                 RESET,
    ddr_lane_delay_sequencer_if.slave train,
    output logic [TAP_W-1:0]     RX_TAP,
    output logic [TAP_W-1:0]     TX_TAP,
    output logic                 DELAY_LINE_SEL,
    output logic                 DELAY_LINE_LOAD,
    output logic                 DELAY_LINE_DIRECTION,
    output logic                 DELAY_LINE_MOVE,
    output logic                 HS_IO_CLK_PAUSE,
    input  logic                 RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic                 TX_DELAY_LINE_OUT_OF_RANGE
);
    localparam int MAX_SH  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int MAX_CNT = (PAUSE_CYCLES > MAX_SH) ? PAUSE_CYCLES : MAX_SH;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] PAUSE_LD = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [2:0] {IDLE, PAUSE_ON, SETUP, STROBE, HOLD, PAUSE_OFF, RESP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             err_q, err_nxt;
    logic [1:0]       op_q, op_cur;
    logic             lane_q, lane_cur;
    logic             accept, tap_upd, sel_oor, line_win, pause_win;
    logic [TAP_W-1:0] acc_tap;
    logic             ready_q, rsp_valid_q, rsp_err_q;

    // Requests that would leave the legal tap range never reach the lane controller.
    function automatic logic tap_blocked(input logic [1:0] op, input logic [TAP_W-1:0] tap);
        tap_blocked = (op == OP_RSVD) ||
                      ((op == OP_INC) && (tap == TAP_W'(MAX_TAP))) ||
                      ((op == OP_DEC) && (tap == '0));
    endfunction

    function automatic logic [TAP_W-1:0] tap_step(input logic [1:0] op, input logic [TAP_W-1:0] tap);
        case (op)
            OP_INC:  tap_step = (tap == TAP_W'(MAX_TAP)) ? tap : tap + TAP_W'(1);
            OP_DEC:  tap_step = (tap == '0) ? tap : tap - TAP_W'(1);
            default: tap_step = TAP_W'(LOAD_TAP);
        endcase
    endfunction

    assign train.REQ_READY = ready_q;
    assign train.RSP_VALID = rsp_valid_q;
    assign train.RSP_ERR   = rsp_err_q;

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err_q <= err_nxt;
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (accept) begin
            op_q   <= train.REQ_OP;
            lane_q <= train.REQ_LANE;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err_q;
        tap_upd   = 1'b0;
        accept    = train.REQ_VALID && ready_q;
        op_cur    = accept ? train.REQ_OP : op_q;
        lane_cur  = accept ? train.REQ_LANE : lane_q;
        acc_tap   = train.REQ_LANE ? TX_TAP : RX_TAP;
        sel_oor   = lane_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
        case (state)
            IDLE: begin
                if (accept) begin
                    err_nxt = 1'b0;
                    if (tap_blocked(train.REQ_OP, acc_tap)) begin
                        state_nxt = RESP;
                        err_nxt   = 1'b1;
                    end else if (train.REQ_OP == OP_LOAD) begin
                        state_nxt = PAUSE_ON;
                        cnt_nxt   = PAUSE_LD;
                    end else begin
                        state_nxt = SETUP;
                        cnt_nxt   = SETUP_LD;
                    end
                end
            end
            PAUSE_ON: begin
                if (cnt == '0) begin
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            SETUP: begin
                if (cnt == '0) state_nxt = STROBE;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            STROBE: begin
                state_nxt = HOLD;
                cnt_nxt   = HOLD_LD;
            end
            HOLD: begin
                if (cnt == '0) begin
                    err_nxt = sel_oor;
                    tap_upd = !sel_oor;
                    if (op_q == OP_LOAD) begin
                        state_nxt = PAUSE_OFF;
                        cnt_nxt   = PAUSE_LD;
                    end else begin
                        state_nxt = RESP;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            PAUSE_OFF: begin
                if (cnt == '0) state_nxt = RESP;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        line_win  = (state_nxt == SETUP) || (state_nxt == STROBE) ||
                    (state_nxt == HOLD) || (state_nxt == PAUSE_OFF);
        pause_win = (op_cur == OP_LOAD) && (line_win || (state_nxt == PAUSE_ON));
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            ready_q              <= 1'b0;
            rsp_valid_q          <= 1'b0;
            rsp_err_q            <= 1'b0;
            DELAY_LINE_SEL       <= 1'b0;
            DELAY_LINE_DIRECTION <= 1'b0;
            DELAY_LINE_MOVE      <= 1'b0;
            DELAY_LINE_LOAD      <= 1'b0;
            HS_IO_CLK_PAUSE      <= 1'b0;
            RX_TAP               <= TAP_W'(LOAD_TAP);
            TX_TAP               <= TAP_W'(LOAD_TAP);
        end else begin
            ready_q              <= (state_nxt == IDLE);
            rsp_valid_q          <= (state_nxt == RESP);
            rsp_err_q            <= (state_nxt == RESP) && err_nxt;
            DELAY_LINE_SEL       <= line_win && lane_cur;
            DELAY_LINE_DIRECTION <= line_win && (op_cur == OP_INC);
            DELAY_LINE_MOVE      <= (state_nxt == STROBE) && (op_cur != OP_LOAD);
            DELAY_LINE_LOAD      <= (state_nxt == STROBE) && (op_cur == OP_LOAD);
            HS_IO_CLK_PAUSE      <= pause_win;
            if (tap_upd) begin
                if (lane_q) TX_TAP <= tap_step(op_q, TX_TAP);
                else        RX_TAP <= tap_step(op_q, RX_TAP);
            end
        end
    end
endmodule

// File: tb/tb_ddr_lane_delay_sequencer.sv
// Randomized bench for ddr_lane_delay_sequencer against a timeline/tap reference model.
module tb_ddr_lane_delay_sequencer;
    localparam int TAP_W = 8, MAX_TAP = 255, LOAD_TAP = 1;
    localparam int SETUP = 2, HOLD = 2, PAUSE = 4;

    logic FAB_CLK = 1'b0;
    logic RESET = 1'b1;
    logic [TAP_W-1:0] RX_TAP, TX_TAP;
    logic SEL, LOAD, DIR, MOVE, PAUSE_O;
    logic RX_OOR = 1'b0, TX_OOR = 1'b0;
    int checks = 0, errors = 0;
    int m_rx = LOAD_TAP, m_tx = LOAD_TAP;

    ddr_lane_delay_sequencer_if bus ();

    ddr_lane_delay_sequencer #(
        .TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .LOAD_TAP(LOAD_TAP),
        .SETUP_CYCLES(SETUP), .HOLD_CYCLES(HOLD), .PAUSE_CYCLES(PAUSE)
    ) dut (
        .FAB_CLK(FAB_CLK), .RESET(RESET), .train(bus),
        .RX_TAP(RX_TAP), .TX_TAP(TX_TAP),
        .DELAY_LINE_SEL(SEL), .DELAY_LINE_LOAD(LOAD),
        .DELAY_LINE_DIRECTION(DIR), .DELAY_LINE_MOVE(MOVE),
        .HS_IO_CLK_PAUSE(PAUSE_O),
        .RX_DELAY_LINE_OUT_OF_RANGE(RX_OOR), .TX_DELAY_LINE_OUT_OF_RANGE(TX_OOR)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_cycle();
        @(posedge FAB_CLK);
        #1;
    endtask

    task automatic check_reset_values();
        chk("rst_ready", bus.REQ_READY, 0);
        chk("rst_rsp_valid", bus.RSP_VALID, 0);
        chk("rst_rsp_err", bus.RSP_ERR, 0);
        chk("rst_outputs", {SEL, LOAD, DIR, MOVE, PAUSE_O}, 0);
        chk("rst_rx_tap", RX_TAP, LOAD_TAP);
        chk("rst_tx_tap", TX_TAP, LOAD_TAP);
    endtask

    task automatic reset_dut();
        bus.REQ_VALID = 1'b0;
        RESET = 1'b1;
        repeat (2) idle_cycle();
        check_reset_values();
        RESET = 1'b0;
        m_rx = LOAD_TAP;
        m_tx = LOAD_TAP;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.REQ_READY !== 1'b1 && n < 20) begin
            idle_cycle();
            n++;
        end
        chk("ready_wait", bus.REQ_READY, 1);
    endtask

    // One request: the model derives the whole expected timeline from the parameters.
    task automatic do_req(input int op, input int lane, input int oor_mode);
        int tap, setup_start, strobe, rsp_exp, inj, new_tap, pause_len;
        bit bypass, err_exp;
        int rsp_c = -1, mv_n = 0, mv_c = -1, ld_n = 0, ld_c = -1, pz_n = 0, pz_first = -1;
        int both_n = 0, sel_bad = 0, dir_bad = 0, err_obs = 0, pz_rsp = 0, sel_rsp = 0;
        int rx_obs = 0, tx_obs = 0;
        tap = lane ? m_tx : m_rx;
        bypass = (op == 3) || (op == 1 && tap == MAX_TAP) || (op == 2 && tap == 0);
        setup_start = (op == 0) ? PAUSE + 1 : 1;
        strobe = setup_start + SETUP;
        rsp_exp = bypass ? 1 : strobe + HOLD + 1 + ((op == 0) ? PAUSE : 0);
        pause_len = (op == 0 && !bypass) ? 2 * PAUSE + SETUP + 1 + HOLD : 0;
        inj = -1;
        if (!bypass) begin
            case (oor_mode)
                1: inj = strobe + HOLD;
                2: inj = strobe - 1;
                3: inj = strobe + 1;
                default: inj = -1;
            endcase
        end
        err_exp = bypass || (inj == strobe + HOLD);
        new_tap = tap;
        if (!err_exp) new_tap = (op == 0) ? LOAD_TAP : (op == 1) ? tap + 1 : tap - 1;

        wait_ready();
        bus.REQ_OP = 2'(op);
        bus.REQ_LANE = 1'(lane);
        bus.REQ_VALID = 1'b1;
        for (int c = 1; c <= 40 && rsp_c < 0; c++) begin
            idle_cycle();
            bus.REQ_VALID = 1'b0;
            if (MOVE && LOAD) both_n++;
            if (MOVE) begin mv_n++; mv_c = c; end
            if (LOAD) begin ld_n++; ld_c = c; end
            if (PAUSE_O) begin pz_n++; if (pz_first < 0) pz_first = c; end
            if (!bypass && c >= setup_start && c <= strobe + HOLD) begin
                if (SEL !== 1'(lane)) sel_bad++;
                if (DIR !== (op == 1)) dir_bad++;
            end
            if (bus.RSP_VALID) begin
                rsp_c = c; err_obs = bus.RSP_ERR; pz_rsp = PAUSE_O; sel_rsp = SEL;
                rx_obs = RX_TAP; tx_obs = TX_TAP;
            end
            if (lane) begin TX_OOR = (c == inj); RX_OOR = 1'($urandom_range(0, 1)); end
            else      begin RX_OOR = (c == inj); TX_OOR = 1'($urandom_range(0, 1)); end
        end
        RX_OOR = 1'b0;
        TX_OOR = 1'b0;

        chk("rsp_cycle", rsp_c, rsp_exp);
        chk("rsp_err", err_obs, err_exp);
        chk("move_count", mv_n, (!bypass && op != 0) ? 1 : 0);
        if (!bypass && op != 0) chk("move_cycle", mv_c, strobe);
        chk("load_count", ld_n, (!bypass && op == 0) ? 1 : 0);
        if (!bypass && op == 0) chk("load_cycle", ld_c, strobe);
        chk("move_load_overlap", both_n, 0);
        chk("pause_len", pz_n, pause_len);
        chk("pause_first", pz_first, (pause_len > 0) ? 1 : -1);
        chk("pause_at_rsp", pz_rsp, 0);
        chk("sel_stable", sel_bad, 0);
        chk("dir_stable", dir_bad, 0);
        chk("sel_at_rsp", sel_rsp, 0);
        if (lane) m_tx = new_tap; else m_rx = new_tap;
        chk("rx_tap", rx_obs, m_rx);
        chk("tx_tap", tx_obs, m_tx);
        idle_cycle();
        chk("ready_after_rsp", bus.REQ_READY, 1);
    endtask

    task automatic reset_during_load();
        int rsp_n = 0;
        wait_ready();
        bus.REQ_OP = 2'b00;
        bus.REQ_LANE = 1'b0;
        bus.REQ_VALID = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            idle_cycle();
            bus.REQ_VALID = 1'b0;
        end
        chk("pause_before_abort", PAUSE_O, 1);
        RESET = 1'b1;
        idle_cycle();
        check_reset_values();
        RESET = 1'b0;
        m_rx = LOAD_TAP;
        m_tx = LOAD_TAP;
        for (int c = 0; c < 20; c++) begin
            idle_cycle();
            if (bus.RSP_VALID) rsp_n++;
        end
        chk("abort_no_rsp", rsp_n, 0);
        chk("abort_ready", bus.REQ_READY, 1);
        do_req(1, 1, 0);
    endtask

    task automatic back_to_back();
        int acc[$];
        int rsp_n = 0;
        bit drop = 0;
        bus.REQ_OP = 2'b01;
        bus.REQ_LANE = 1'b0;
        bus.REQ_VALID = 1'b1;
        for (int c = 0; c < 60; c++) begin
            idle_cycle();
            if (drop) bus.REQ_VALID = 1'b0;
            if (bus.RSP_VALID) rsp_n++;
            if (bus.REQ_VALID && bus.REQ_READY) acc.push_back(c);
            if (acc.size() == 4) drop = 1;
        end
        chk("b2b_accepts", acc.size(), 4);
        for (int i = 1; i < acc.size(); i++)
            chk("b2b_spacing", acc[i] - acc[i-1], SETUP + 1 + HOLD + 1 + 1);
        chk("b2b_rsp_count", rsp_n, 4);
        m_rx = m_rx + 4;
        chk("b2b_rx_tap", RX_TAP, m_rx);
    endtask

    initial begin
        bus.REQ_VALID = 1'b0;
        bus.REQ_OP = 2'b00;
        bus.REQ_LANE = 1'b0;
        reset_dut();

        do_req(1, 1, 0);
        repeat (3) do_req(1, 0, 0);
        do_req(0, 0, 0);
        do_req(2, 0, 0);
        do_req(2, 0, 0);
        do_req(3, 0, 0);
        do_req(1, 1, 1);
        do_req(1, 1, 2);
        do_req(1, 1, 3);
        do_req(0, 1, 1);

        for (int i = 0; i < 80; i++) begin
            int r, op;
            r = $urandom_range(0, 9);
            op = (r == 0) ? 0 : (r <= 4) ? 1 : (r <= 8) ? 2 : 3;
            do_req(op, $urandom_range(0, 1), $urandom_range(0, 3));
        end

        reset_during_load();

        reset_dut();
        back_to_back();

        reset_dut();
        for (int i = 0; i < MAX_TAP - LOAD_TAP; i++) do_req(1, 1, 0);
        chk("tx_at_max", TX_TAP, MAX_TAP);
        do_req(1, 1, 0);
        do_req(2, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
